// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types and constants for the multi-cycle shift
//                sequencer: shift-mode and FSM-state encodings plus the
//                default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  // Default operand width for the sequencer and its one-bit stage
  localparam int DEFAULT_WIDTH = 4;

  // Shift operation selected per request
  typedef enum logic [1:0] {
    SH_LR = 2'b00,  // logical right
    SH_AR = 2'b01,  // arithmetic right
    SH_LL = 2'b10,  // logical left
    SH_RR = 2'b11   // rotate right (only with SHIFT_ROTATE_EN)
  } shift_mode_t;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_t;

endpackage
`default_nettype wire

// File: rtl/shift1_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift1_stage
//  Description : Purely combinational single-bit shifter. Applies one step of
//                logical-right, arithmetic-right, logical-left or
//                rotate-right to d according to mode.
//                Macro SHIFT_ROTATE_EN: when defined, mode 11 rotates right;
//                when undefined, mode 11 falls back to logical right and the
//                rotate leg is not built.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift1_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] d,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] q
);

  // Select one single-bit shift step; unknown/disabled modes act as logical right
  always_comb begin
    q = {1'b0, d[WIDTH-1:1]};
    case (mode)
      SH_AR:   q = {d[WIDTH-1], d[WIDTH-1:1]};
      SH_LL:   q = {d[WIDTH-2:0], 1'b0};
`ifdef SHIFT_ROTATE_EN
      SH_RR:   q = {d[0], d[WIDTH-1:1]};
`endif
      default: q = {1'b0, d[WIDTH-1:1]};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Multi-cycle shift engine. Accepts operand/mode/amount over a
//                valid/ready handshake, applies the one-bit shift stage once
//                per clock amt times, then holds the result on a valid/ready
//                output port until it is taken.
//                Macro SHIFT_ROTATE_EN: enables rotate-right for mode 11 in
//                the one-bit stage; otherwise mode 11 acts as logical right.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  shift_state_t     r_state;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;
  shift_mode_t      r_mode;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] w_shifted;

  // Single shared one-bit datapath, reused every SHIFT cycle
  shift1_stage #(
    .WIDTH (WIDTH)
  ) u_shift1 (
    .d    (r_data),
    .mode (r_mode),
    .q    (w_shifted)
  );

  // Control FSM with registered handshake outputs; data/cnt/mode held except on accept or shift step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_data      <= '0;
      r_cnt       <= '0;
      r_mode      <= SH_LR;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data     <= in_data;
            r_cnt      <= in_amt;
            r_mode     <= shift_mode_t'(in_mode);
            r_in_ready <= 1'b0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_cnt == '0) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_data <= w_shifted;
            r_cnt  <= r_cnt - AMT_W'(1);
          end
        end
        ST_DONE: begin
          // Handshake drops to IDLE; the next accept can only happen one cycle later
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_sequencer
//  Description : Directed self-checking bench for shift_sequencer
//                (WIDTH=4, AMT_W=2). Expected values are hand-computed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_amt;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;

  int vectors;
  int miscompares;

  shift_sequencer #(
    .WIDTH (4),
    .AMT_W (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for a single edge; caller is 1ns after an edge with in_ready high.
  // Returns 1ns after the accepting edge with inputs scrambled.
  task automatic accept(input logic [3:0] d, input logic [1:0] m, input logic [1:0] a);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_amt   = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 4'($urandom);
    in_mode  = 2'($urandom);
    in_amt   = 2'($urandom);
  endtask

  // Count edges after the accept until out_valid is seen; -1 if it never rises
  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (out_data !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_out_data: got %b expected 0000", out_data);
    end
  endtask

  task automatic test_arith_right;
    int lat;
    out_ready = 1'b1;
    accept(4'b1010, 2'b01, 2'd1);
    wait_out(lat);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL ar1_latency: got %0d expected 2", lat);
    end
    vectors++;
    if (out_data !== 4'b1101) begin
      miscompares++;
      $display("FAIL ar1_data: got %b expected 1101", out_data);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ar1_after_handshake: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_logical_and_ar3;
    int lat;
    out_ready = 1'b1;
    accept(4'b1010, 2'b00, 2'd1);
    wait_out(lat);
    vectors++;
    if (lat !== 2 || out_data !== 4'b0101) begin
      miscompares++;
      $display("FAIL lr1: got lat=%0d data=%b expected lat=2 data=0101", lat, out_data);
    end
    @(posedge clk);
    #1;
    accept(4'b1000, 2'b01, 2'd3);
    wait_out(lat);
    vectors++;
    if (lat !== 4 || out_data !== 4'b1111) begin
      miscompares++;
      $display("FAIL ar3: got lat=%0d data=%b expected lat=4 data=1111", lat, out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_amt0_and_left;
    int lat;
    out_ready = 1'b1;
    accept(4'b0110, 2'b11, 2'd0);
    wait_out(lat);
    vectors++;
    if (lat !== 1 || out_data !== 4'b0110) begin
      miscompares++;
      $display("FAIL amt0: got lat=%0d data=%b expected lat=1 data=0110", lat, out_data);
    end
    @(posedge clk);
    #1;
    accept(4'b0110, 2'b10, 2'd2);
    wait_out(lat);
    vectors++;
    if (lat !== 3 || out_data !== 4'b1000) begin
      miscompares++;
      $display("FAIL ll2: got lat=%0d data=%b expected lat=3 data=1000", lat, out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    out_ready = 1'b0;
    accept(4'b1010, 2'b01, 2'd1);
    wait_out(lat);
    vectors++;
    if (lat !== 2 || out_data !== 4'b1101) begin
      miscompares++;
      $display("FAIL bp_result: got lat=%0d data=%b expected lat=2 data=1101", lat, out_data);
    end
    // Offer a competing request while stalled; it must be ignored
    in_valid = 1'b1;
    in_data  = 4'b0011;
    in_mode  = 2'b10;
    in_amt   = 2'd0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_data !== 4'b1101 || in_ready !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL bp_hold: got %0d unstable cycles expected 0 (last valid=%b data=%b ready=%b)", bad, out_valid, out_data, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_no_ghost: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_rotate;
    int lat;
    logic [3:0] exp;
`ifdef SHIFT_ROTATE_EN
    exp = 4'b1100;
`else
    exp = 4'b0100;
`endif
    out_ready = 1'b1;
    accept(4'b1001, 2'b11, 2'd1);
    wait_out(lat);
    vectors++;
    if (lat !== 2 || out_data !== exp) begin
      miscompares++;
      $display("FAIL rr1: got lat=%0d data=%b expected lat=2 data=%b", lat, out_data, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int lat;
    int ghost;
    out_ready = 1'b1;
    accept(4'b1111, 2'b00, 2'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset: got valid=%b ready=%b data=%b expected 0/1/0000", out_valid, in_ready, out_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ghost = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) ghost++;
    end
    vectors++;
    if (ghost !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_stale: got %0d valid cycles expected 0", ghost);
    end
    accept(4'b0011, 2'b10, 2'd1);
    wait_out(lat);
    vectors++;
    if (lat !== 2 || out_data !== 4'b0110) begin
      miscompares++;
      $display("FAIL mid_reset_fresh: got lat=%0d data=%b expected lat=2 data=0110", lat, out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int n;
    int lat;
    logic r;
    out_ready = 1'b1;
    accept(4'b1100, 2'b00, 2'd2);
    // Hold the next request continuously and count edges until it is taken
    in_valid = 1'b1;
    in_data  = 4'b0001;
    in_mode  = 2'b10;
    in_amt   = 2'd3;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      r = in_ready;
      @(posedge clk);
      if (r) begin
        n = i;
        break;
      end
      #1;
      if (i == 3 && out_data !== 4'b0011) begin
        vectors++;
        miscompares++;
        $display("FAIL b2b_first_data: got %b expected 0011", out_data);
      end
    end
    #1;
    in_valid = 1'b0;
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL b2b_period: got %0d expected 5", n);
    end
    wait_out(lat);
    vectors++;
    if (lat !== 4 || out_data !== 4'b1000) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d data=%b expected lat=4 data=1000", lat, out_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 4'b0000;
    in_amt      = 2'd0;
    in_mode     = 2'b00;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_arith_right;
    test_logical_and_ar3;
    test_amt0_and_left;
    test_backpressure;
    test_rotate;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift engine that sits directly upstream of the consumer of the single-bit right-shift stage. It accepts an operand, mode and shift amount over a valid/ready handshake. It applies the one-bit shift stage once per clock, `amt` times, and presents the result on a valid/ready output port. The one-bit stage is reused unchanged as its datapath, so shifts of any amount cost no extra combinational depth.

## Interface
- `WIDTH`, default 4: operand width in bits; must be ≥2.
- `AMT_W`, default 2: shift-amount width, equal to `$clog2(WIDTH)`; the maximum shift is WIDTH-1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; the design uses one clock, and reset is asynchronous and active-low.
- `in_valid`  in  1  a request is present.
- `in_ready`  out  1  the block can accept a request; high only in IDLE.
- `in_data`  in  WIDTH  operand.
- `in_amt`  in  AMT_W  number of single-bit shift steps.
- `in_mode`  in  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
- `out_valid`  out  1  the result is held on `out_data`.
- `out_ready`  in  1  the downstream stage accepts the result.
- `out_data`  out  WIDTH  shifted result; stable while `out_valid` is high.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: load the data register ← `in_data`, `cnt` ← `in_amt`, `mode` ← `in_mode`, and go to SHIFT.
- SHIFT:
  - If `cnt`==0, go to DONE.
  - Otherwise, data ← shift1(data, mode) and `cnt` ← `cnt`-1, staying in SHIFT.
- shift1 behaviour per mode:
  - LR: {0, d[W-1:1]}.
  - AR: {d[W-1], d[W-1:1]}.
  - LL: {d[W-2:0], 0}.
  - RR: {d[0], d[W-1:1]}.
- DONE:
  - `out_valid`=1.
  - On `out_valid`&`out_ready`, go to IDLE.
  - `out_data` and all registers are frozen while backpressured.
- Inputs are ignored outside IDLE; `in_data`, `in_amt` and `in_mode` need not be held after the accepting edge.
- No arithmetic overflow or wrap: `cnt` only decrements and never goes below 0.

## Timing
- Reset values:
  - state=IDLE, data=0, `cnt`=0, `mode`=00.
  - `in_ready`=1, `out_valid`=0, `out_data`=0.
- Outputs are decoded from registered state only; there is no input-to-output combinational path.
- Latency: `out_valid` rises amt+1 rising edges after the accepting edge.
  - amt=0 gives 1 cycle, with the result equal to the operand.
- Throughput: one operation per amt+3 cycles with `out_ready` tied high.
  - DONE→IDLE costs one cycle; there is no accept in the same cycle as the output handshake.
- Back-to-back: `in_ready` rises in the cycle after the output handshake.
- Reset asserted mid-operation: the operation is aborted immediately and asynchronously, and no result is emitted. After deassertion the block behaves as from reset.
- If `out_ready` is already high when DONE is entered, the handshake completes on the first DONE cycle.

## Configuration
- `SHIFT_ROTATE_EN` defined: mode 11 performs rotate right as specified above.
- `SHIFT_ROTATE_EN` undefined:
  - Mode 11 is decoded as logical right (00).
  - The rotate mux leg is absent from the synthesized logic.
  - Ports and timing are unchanged.

## Structure
- Package `shift_pkg`:
  - `shift_mode_t` enum (`SH_LR`, `SH_AR`, `SH_LL`, `SH_RR`).
  - `shift_state_t` enum (`ST_IDLE`, `ST_SHIFT`, `ST_DONE`).
  - Default `WIDTH` constant.
- Sub-module `shift1_stage`: purely combinational one-bit shifter, with `d`, `mode` → `q`, parameterized by `WIDTH`. It holds the `SHIFT_ROTATE_EN` guard. `shift_sequencer` instantiates it once and owns the FSM, `cnt` and the data register.

## Test plan
- in_data=1010, mode=AR, amt=1, `out_ready`=1 → `out_valid` 2 cycles after accept with `out_data`=1101.
- in_data=1010, mode=LR, amt=1 → `out_data`=0101. Then in_data=1000, mode=AR, amt=3 → 1111 after 4 cycles.
- in_data=0110, amt=0 (any mode) → `out_data`=0110 one cycle after accept. Mode=LL, amt=2 → 1000.
- Backpressure: result 1101 with `out_ready`=0 for 5 cycles → `out_valid` and `out_data` are stable, `in_ready`=0, and a new `in_valid` is ignored. Raising `out_ready` gives one handshake, then `in_ready`=1 on the next cycle.
- in_data=1001, mode=RR, amt=1 → 1100 with `SHIFT_ROTATE_EN`, and 0100 without it.
- Assert `rst_n`=0 during SHIFT (amt=3, after 1 step) → immediately `out_valid`=0, `in_ready`=1, `out_data`=0. After release, no stale result appears and a fresh request completes normally.
